// File: rtl/sram_port_arbiter.sv
// Two-requester SRAM port arbiter: round-robin with a bounded lock for read-modify-write,
// plus an RD_LAT-deep return pipeline that routes ram_rdata back to the issuing requester.
module sram_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                req0,
  input  logic                req1,
  input  logic                wen0,
  input  logic                wen1,
  input  logic                lock0,
  input  logic                lock1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic [DATA_W/8-1:0] be0,
  input  logic [DATA_W/8-1:0] be1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [DATA_W-1:0]   rdata0,
  output logic [DATA_W-1:0]   rdata1,
  output logic                ram_en,
  output logic                ram_wen,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_be,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                lock_active,
  output logic                lock_owner
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_any, sel, sel_wen, sel_lock, own_req, own_lock;
  logic [RD_LAT:1]  vld_p;
  logic [RD_LAT:1]  id_p;
  logic             ret_vld;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= UNLOCKED;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    own_req    = owner_q ? req1 : req0;
    own_lock   = owner_q ? lock1 : lock0;

    if (state_q == UNLOCKED) begin
      if (req0 && req1) begin
        gnt0 = last_gnt_q;
        gnt1 = !last_gnt_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end else begin
      gnt0 = req0 && !owner_q;
      gnt1 = req1 && owner_q;
    end
    if (!HRESETn) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    gnt_any  = gnt0 || gnt1;
    sel      = gnt1;
    sel_lock = sel ? lock1 : lock0;
    sel_wen  = sel ? wen1 : wen0;
    if (gnt_any) last_gnt_d = sel;

    if (state_q == UNLOCKED) begin
      if (gnt_any && sel_lock) begin
        state_d = LOCKED;
        owner_d = sel;
        cnt_d   = CNT_W'(1);
      end
    end else begin
      cnt_d = sat_inc(cnt_q);
      // Release on owner unlock, owner idle, or the counter reaching its bound.
      if (!own_req || !own_lock || (cnt_q == CNT_MAX)) begin
        state_d    = UNLOCKED;
        owner_d    = 1'b0;
        cnt_d      = '0;
        last_gnt_d = owner_q;
      end
    end
  end

  assign ram_en    = gnt_any;
  assign ram_wen   = gnt_any && sel_wen;
  assign ram_addr  = gnt_any ? (sel ? addr1 : addr0) : '0;
  assign ram_wdata = gnt_any ? (sel ? wdata1 : wdata0) : '0;
  assign ram_be    = gnt_any ? (sel ? be1 : be0) : '0;

  // p1..pRD_LAT: read-return tracking, one slot per SRAM latency cycle
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      vld_p <= '0;
    end else begin
      for (int k = RD_LAT; k > 1; k--) vld_p[k] <= vld_p[k-1];
      vld_p[1] <= gnt_any && !sel_wen;
    end
  end

  always_ff @(posedge HCLK) begin
    for (int k = RD_LAT; k > 1; k--) id_p[k] <= id_p[k-1];
    id_p[1] <= sel;
  end

  assign ret_vld     = vld_p[RD_LAT] && HRESETn;
  assign rvalid0     = ret_vld && !id_p[RD_LAT];
  assign rvalid1     = ret_vld && id_p[RD_LAT];
  assign rdata0      = rvalid0 ? ram_rdata : '0;
  assign rdata1      = rvalid1 ? ram_rdata : '0;
  assign lock_active = (state_q == LOCKED);
  assign lock_owner  = (state_q == LOCKED) && owner_q;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single SRAM macro port between two requesters.
- Requester 0 is the AHB SRAM slave; requester 1 is the DMA/debug master.
- Uses round-robin arbitration, an optional bounded lock for read-modify-write sequences, and an RD_LAT-deep return pipeline that routes read data back to the owning requester.
- Sits between the requesters and the SRAM macro.

Parameters:
- ADDR_W, 16, SRAM address width in bits.
- DATA_W, 32, data width in bits; byte enables are DATA_W/8 wide.
- RD_LAT, 1, cycles from a granted read to ram_rdata valid; legal values 1..3.
- LOCK_MAX, 16, maximum consecutive locked cycles before a forced release; must be ≥1.

Ports:
- HCLK  in  1  system clock; all state updates on its rising edge.
- HRESETn  in  1  synchronous active-low reset.
- req0, req1  in  1 each  access request; held until the matching gnt.
- wen0, wen1  in  1 each  1 = write, 0 = read.
- lock0, lock1  in  1 each  request to keep ownership after this access.
- addr0, addr1  in  ADDR_W each  access address.
- wdata0, wdata1  in  DATA_W each  write data.
- be0, be1  in  DATA_W/8 each  byte enables.
- gnt0, gnt1  out  1 each  access accepted this cycle (combinational).
- rvalid0, rvalid1  out  1 each  read data valid for that requester.
- rdata0, rdata1  out  DATA_W each  read data.
- ram_en  out  1  SRAM access strobe.
- ram_wen  out  1  SRAM write enable.
- ram_addr  out  ADDR_W  SRAM address.
- ram_wdata  out  DATA_W  SRAM write data.
- ram_be  out  DATA_W/8  SRAM byte enables.
- ram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after the access.
- lock_active  out  1  arbiter is in LOCKED.
- lock_owner  out  1  owner while LOCKED; 0 otherwise.

Behaviour:
- Reset state (HRESETn=0 sampled at an edge):
  - state=UNLOCKED, last_gnt=1 (so requester 0 wins the first tie), lock counter=0, return pipeline cleared.
  - While HRESETn=0, gnt*, ram_en, ram_wen, rvalid* are forced to 0; ram_addr, ram_wdata, ram_be, rdata* are 0.
- Transfer handshake:
  - A transaction occurs in any cycle where reqN && gntN.
  - ram_* carries requester N's wen/addr/wdata/be combinationally that same cycle; ram_en=1.
  - With no grant: ram_en=0, ram_wen=0, other ram_* = 0.
  - At most one gnt per cycle.
- UNLOCKED arbitration:
  - A single requester is granted every cycle it requests (back-to-back allowed).
  - When both request, the requester that is not last_gnt is granted.
  - last_gnt updates on every grant.
- Lock state machine:
  - UNLOCKED -> LOCKED(owner=N) when N is granted with lockN=1; counter loads 1.
  - In LOCKED, only the owner can be granted; the other requester's req is ignored. The counter increments every LOCKED cycle, saturating at LOCK_MAX.
  - LOCKED -> UNLOCKED on the first of:
    - (a) the owner is granted with lockN=0; that access still completes;
    - (b) the owner's req=0 in a LOCKED cycle;
    - (c) the counter equals LOCK_MAX at a clock edge (forced release).
  - After (c), last_gnt=owner, so the other requester wins the next contention.
  - Exit takes effect next cycle; in the exit cycle the non-owner is still not granted.
- Read return:
  - Each granted read pushes {valid=1, id=N} into an RD_LAT-stage shift register; writes and idle cycles push valid=0.
  - When the stage-RD_LAT entry is valid, rvalid[id]=1 and rdata[id]=ram_rdata (combinational); the other requester's rdata=0.
  - Pipelined back-to-back reads from either requester return in issue order, one per cycle.
- Reset mid-operation:
  - In-flight reads are discarded and no rvalid follows.
  - Lock is released and state returns to reset values.
- Writes never produce rvalid; there is no write response.

Test Plan:
- Reset, then req0 write addr=0x0010, wdata=0xDEADBEEF, be=0xF → gnt0=1 same cycle; ram_en=1, ram_wen=1, ram_addr=0x0010, ram_wdata=0xDEADBEEF; no rvalid.
- RD_LAT=1: req0 read 0x0004 and req1 read 0x0008 both asserted, ram_rdata returns 0x11111111 then 0x22222222 → gnt0 in cycle 1, gnt1 in cycle 2; rvalid0/rdata0=0x11111111 in cycle 2, rvalid1/rdata1=0x22222222 in cycle 3.
- Both requesters hold req continuously for 6 cycles → grants alternate 0,1,0,1,0,1 and ram_en=1 every cycle.
- req1 granted with lock1=1, then three locked accesses, then lock1=0, while req0 is held high throughout → gnt0 stays 0 for the whole sequence; lock_active=1 and lock_owner=1 until the lock1=0 access; gnt0=1 on the following cycle.
- LOCK_MAX=4: req0 holds req0=1, lock0=1 indefinitely while req1 is held high → lock_active drops after 4 locked cycles, then gnt1=1 next cycle.
- RD_LAT=3: issue a read, assert HRESETn=0 for one cycle at the second edge → rvalid0 never asserts; after reset, a req1/req0 tie grants requester 0 first.
